// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared widths and owner encoding for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  // Machine word width shared with the rest of the core's ISA definitions.
  localparam int XLEN_DEFAULT = 32;

  // Wide enough for MAX_DATA_STREAK up to 15.
  localparam int STREAK_W = 4;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_priority.sv
// ============================================================================
// Module   : arb_priority
// Purpose  : Data-over-fetch grant logic with a saturating data-streak counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_priority
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam logic [STREAK_W-1:0] C_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic                w_fetch_due;

  always_comb begin
    w_fetch_due = if_valid && (r_streak == C_MAX);
    grant_d     = en && d_valid && !w_fetch_due;
    grant_if    = en && if_valid && !grant_d;
  end

  // Counts data grants that were made while fetch was left waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (grant_if) begin
      r_streak <= '0;
    end else if (grant_d) begin
      if (!if_valid) begin
        r_streak <= '0;
      end else if (r_streak != C_MAX) begin
        r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Single-outstanding arbiter between instruction fetch and
//            load/store for one shared memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_wstrb,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              busy,
  output logic              err
);

  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_owner;
  logic                r_we;
  logic [XLEN-1:0]     r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                w_arb_en;
  logic                w_grant_if;
  logic                w_grant_d;

  // Gating with rst keeps the ready outputs at 0 while reset is held.
  assign w_arb_en = (r_state == ST_IDLE) && !rst;

  arb_priority #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_arb_priority (
    .clk      (clk),
    .rst      (rst),
    .en       (w_arb_en),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .grant_if (w_grant_if),
    .grant_d  (w_grant_d)
  );

  assign if_req_ready  = w_grant_if;
  assign d_req_ready   = w_grant_d;
  assign busy          = (r_state != ST_IDLE);
  assign mem_req_valid = (r_state == ST_ISSUE);
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_grant_if || w_grant_d) w_state_next = ST_ISSUE;
      ST_ISSUE:    if (mem_req_ready)           w_state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (mem_rsp_valid)           w_state_next = ST_IDLE;
      default:                                  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture; reads always present zero strobes to memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWNER_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_grant_d) begin
      r_owner <= OWNER_D;
      r_we    <= d_req_we;
      r_addr  <= d_req_addr;
      r_wdata <= d_req_wdata;
      r_wstrb <= d_req_we ? d_req_wstrb : '0;
    end else if (w_grant_if) begin
      r_owner <= OWNER_IF;
      r_we    <= 1'b0;
      r_addr  <= if_req_addr;
      r_wdata <= '0;
      r_wstrb <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_rdata  <= '0;
      err          <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if ((r_state == ST_WAIT_RSP) && mem_rsp_valid) begin
        if (r_owner == OWNER_D) begin
          d_rsp_valid <= 1'b1;
          d_rsp_rdata <= r_we ? '0 : mem_rsp_rdata;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rsp_rdata;
        end
      end
      if (mem_rsp_valid && (r_state != ST_WAIT_RSP)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized transaction-level check of mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_wstrb, mem_req_wstrb;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic        busy, err;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // Requesters and memory environment
  bit          f_pend, d_pend, d_we, spur, rsp_pend;
  logic [31:0] f_addr, d_addr, d_wdata, rsp_data;
  logic [3:0]  d_wstrb;
  int          f_rate, d_rate, rdy_rate, lat_min, lat_max, rsp_wait;
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  // Transaction-level reference model
  bit          m_active, m_issued, m_owner_d, m_we, m_err, e_if, e_d;
  logic [31:0] m_addr, m_wdata, e_if_data, e_d_data;
  logic [3:0]  m_wstrb;
  int          m_streak;

  // Observations used by the directed literal checks
  int          n_if, n_d, n_we_issue;
  logic [31:0] last_if;
  logic [31:0] d_hist[$];
  string       glog;

  function automatic logic [31:0] rdm(input logic [31:0] a, input bit use_ref);
    if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_0000);
    return dut_mem.exists(a) ? dut_mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_if_ready"}, if_req_ready, 1'b0);
    chk1({tag, "_d_ready"}, d_req_ready, 1'b0);
    chk1({tag, "_if_rsp_valid"}, if_rsp_valid, 1'b0);
    chk1({tag, "_d_rsp_valid"}, d_rsp_valid, 1'b0);
    chk32({tag, "_if_rsp_data"}, if_rsp_data, 32'h0);
    chk32({tag, "_d_rsp_rdata"}, d_rsp_rdata, 32'h0);
    chk1({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk1({tag, "_mem_req_we"}, mem_req_we, 1'b0);
    chk32({tag, "_mem_req_addr"}, mem_req_addr, 32'h0);
    chk32({tag, "_mem_req_wdata"}, mem_req_wdata, 32'h0);
    chk32({tag, "_mem_req_wstrb"}, {28'h0, mem_req_wstrb}, 32'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance model.
  task automatic step();
    bit gf, gd;
    if (!f_pend && (int'($urandom_range(99)) < f_rate)) begin
      f_pend = 1'b1;
      f_addr = 32'h200 + 32'($urandom_range(15)) * 32'd4;
    end
    if (!d_pend && (int'($urandom_range(99)) < d_rate)) begin
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(1));
      d_addr  = 32'h200 + 32'($urandom_range(15)) * 32'd4;
      d_wdata = $urandom;
      d_wstrb = 4'($urandom_range(15));
    end
    if_req_valid  = f_pend;
    if_req_addr   = f_addr;
    d_req_valid   = d_pend;
    d_req_we      = d_we;
    d_req_addr    = d_addr;
    d_req_wdata   = d_wdata;
    d_req_wstrb   = d_wstrb;
    mem_req_ready = int'($urandom_range(99)) < rdy_rate;
    mem_rsp_valid = (rsp_pend && rsp_wait == 0) || spur;
    mem_rsp_rdata = (rsp_pend && rsp_wait == 0) ? rsp_data : $urandom;
    #1;
    gd = !m_active && d_pend && !(f_pend && m_streak == MAXS);
    gf = !m_active && f_pend && !gd;
    chk1("if_req_ready", if_req_ready, gf);
    chk1("d_req_ready", d_req_ready, gd);
    chk1("busy", busy, m_active);
    chk1("mem_req_valid", mem_req_valid, m_active && !m_issued);
    if (m_active && !m_issued) begin
      chk32("mem_req_addr", mem_req_addr, m_addr);
      chk1("mem_req_we", mem_req_we, m_we);
      chk32("mem_req_wstrb", {28'h0, mem_req_wstrb}, {28'h0, (m_we ? m_wstrb : 4'h0)});
      if (m_we) chk32("mem_req_wdata", mem_req_wdata, m_wdata);
    end
    chk1("if_rsp_valid", if_rsp_valid, e_if);
    if (e_if) chk32("if_rsp_data", if_rsp_data, e_if_data);
    chk1("d_rsp_valid", d_rsp_valid, e_d);
    if (e_d) chk32("d_rsp_rdata", d_rsp_rdata, e_d_data);
    chk1("err", err, m_err);

    if (if_rsp_valid) begin n_if++; last_if = if_rsp_data; end
    if (d_rsp_valid) begin n_d++; d_hist.push_back(d_rsp_rdata); end
    if (mem_req_valid && mem_req_we) n_we_issue++;
    if (if_req_ready) glog = {glog, "F"};
    if (d_req_ready) glog = {glog, "D"};

    // Memory acts on what it actually sees on the port.
    if (rsp_pend && rsp_wait == 0) rsp_pend = 1'b0;
    else if (rsp_pend) rsp_wait--;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) dut_mem[mem_req_addr] = merge(rdm(mem_req_addr, 1'b0), mem_req_wdata, mem_req_wstrb);
      rsp_data = mem_req_we ? $urandom : rdm(mem_req_addr, 1'b0);
      rsp_pend = 1'b1;
      rsp_wait = int'($urandom_range(lat_max, lat_min));
    end

    e_if = 1'b0;
    e_d  = 1'b0;
    if (mem_rsp_valid && m_active && m_issued) begin
      if (m_owner_d) begin e_d = 1'b1; e_d_data = m_we ? 32'h0 : rdm(m_addr, 1'b1); end
      else begin e_if = 1'b1; e_if_data = rdm(m_addr, 1'b1); end
      m_active = 1'b0;
    end else if (mem_rsp_valid) begin
      m_err = 1'b1;
    end
    if (m_active && !m_issued && mem_req_ready) begin
      m_issued = 1'b1;
      if (m_we) ref_mem[m_addr] = merge(rdm(m_addr, 1'b1), m_wdata, m_wstrb);
    end
    if (gd) begin
      m_active = 1'b1; m_issued = 1'b0; m_owner_d = 1'b1;
      m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
      m_streak = f_pend ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      d_pend = 1'b0;
    end else if (gf) begin
      m_active = 1'b1; m_issued = 1'b0; m_owner_d = 1'b0;
      m_we = 1'b0; m_addr = f_addr; m_wdata = 32'h0; m_wstrb = 4'h0;
      m_streak = 0;
      f_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f_pend = 0; d_pend = 0; rsp_pend = 0; spur = 0;
    m_active = 0; m_issued = 0; m_err = 0; m_streak = 0; e_if = 0; e_d = 0;
    if_req_valid = 0; d_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((m_active || f_pend || d_pend || rsp_pend) && k < max) begin
      step();
      k++;
    end
    chk1("drain_in_time", k < max, 1'b1);
    step();
  endtask

  initial begin
    f_rate = 0; d_rate = 0; rdy_rate = 100; lat_min = 0; lat_max = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_we = 0;
    if_req_addr = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_req_wstrb = 0;
    mem_rsp_rdata = 0; glog = "";
    if_req_valid = 0; d_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    do_reset();

    // Single fetch, memory answers two cycles after accept
    dut_mem[32'h100] = 32'h0050_0093;
    ref_mem[32'h100] = 32'h0050_0093;
    lat_min = 1; lat_max = 1; n_if = 0; n_d = 0;
    f_pend = 1'b1; f_addr = 32'h100;
    repeat (8) step();
    chk32("single_fetch_count", n_if, 32'd1);
    chk32("single_fetch_data", last_if, 32'h0050_0093);
    chk32("single_fetch_no_d", n_d, 32'd0);

    // Store then load to the same word
    lat_min = 0; lat_max = 0; n_we_issue = 0; d_hist.delete();
    d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    drain(20);
    d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0; d_wstrb = 4'h0;
    drain(20);
    chk32("st_ld_we_cycles", n_we_issue, 32'd1);
    chk32("st_ld_rsp_count", d_hist.size(), 32'd2);
    chk32("store_rsp_zero", (d_hist.size() > 0) ? d_hist[0] : 32'hFFFF_FFFF, 32'h0);
    chk32("load_rsp_data", (d_hist.size() > 1) ? d_hist[1] : 32'h0, 32'hDEAD_BEEF);

    // Fairness under continuous contention
    do_reset();
    glog = ""; f_rate = 100; d_rate = 100;
    repeat (40) step();
    checks++;
    if (glog.substr(0, 9) != "DDDDFDDDDF") begin
      failures++;
      $display("FAIL fairness_order: got %s expected DDDDFDDDDF...", glog);
    end
    f_rate = 0; d_rate = 0;
    drain(40);

    // Backpressure: memory holds ready low while both sides wait
    rdy_rate = 0;
    d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
    f_pend = 1'b1; f_addr = 32'h208;
    repeat (6) step();
    chk1("bp_busy", busy, 1'b1);
    chk32("bp_mem_addr", mem_req_addr, 32'h204);
    chk1("bp_mem_valid", mem_req_valid, 1'b1);
    rdy_rate = 100;
    drain(40);

    // Randomized traffic
    f_rate = 40; d_rate = 50; rdy_rate = 70; lat_min = 0; lat_max = 3;
    repeat (3000) step();
    f_rate = 0; d_rate = 0; rdy_rate = 100;
    drain(100);

    // Spurious response while idle
    n_if = 0; n_d = 0;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (4) step();
    chk1("spur_err_sticky", err, 1'b1);
    chk32("spur_no_rsp", n_if + n_d, 32'd0);

    // Reset in the middle of a transaction
    do_reset();
    chk1("rst_err_clear", err, 1'b0);
    lat_min = 6; lat_max = 6;
    f_pend = 1'b1; f_addr = 32'h20C;
    begin
      int k;
      k = 0;
      while (!(m_active && m_issued) && k < 20) begin step(); k++; end
      chk1("reach_wait_rsp", m_active && m_issued, 1'b1);
    end
    step();
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    do_reset();
    lat_min = 0; lat_max = 0; n_if = 0;
    f_pend = 1'b1; f_addr = 32'h100;
    drain(20);
    chk32("post_rst_fetch_count", n_if, 32'd1);
    chk32("post_rst_fetch_data", last_if, 32'h0050_0093);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch and the load/store path. Load/store is driven by `is_load`/`is_store` decoded from the opcode. The block allows one outstanding transaction at a time and registers the request toward memory. It returns the response to the requester that owns the transaction. Data has priority over fetch, and a bounded-streak rule guarantees fetch forward progress.

## Interface
- `XLEN`, default 32 (from `rtl/isa.v`): address and data width.
- `MAX_DATA_STREAK`, default 4: maximum number of consecutive data grants while fetch is waiting; range 1–15.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `if_req_valid`  in  1  fetch request.
- `if_req_addr`  in  XLEN  fetch address.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_rsp_valid`  out  1  one-cycle pulse; fetch data valid.
- `if_rsp_data`  out  XLEN  fetched word.
- `d_req_valid`  in  1  load/store request.
- `d_req_we`  in  1  1 = store.
- `d_req_addr`  in  XLEN  data address.
- `d_req_wdata`  in  XLEN  store data.
- `d_req_wstrb`  in  XLEN/8  store byte enables.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_rsp_valid`  out  1  one-cycle pulse; load data or store ack.
- `d_rsp_rdata`  out  XLEN  load data; 0 for stores.
- `mem_req_valid`  out  1  request to memory.
- `mem_req_we`  out  1  write enable to memory.
- `mem_req_addr`  out  XLEN  memory address.
- `mem_req_wdata`  out  XLEN  memory write data.
- `mem_req_wstrb`  out  XLEN/8  memory byte enables; all 0 for reads.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rsp_valid`  in  1  memory response; one per request, writes included.
- `mem_rsp_rdata`  in  XLEN  memory read data.
- `busy`  out  1  high when the FSM is not in IDLE.
- `err`  out  1  sticky; set on an unexpected `mem_rsp_valid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP.
- **IDLE**
  - Grant is combinational; `*_req_ready` is high only in IDLE, for the granted requester.
  - On grant, capture the request, record `owner` (0 = fetch, 1 = data), and go to ISSUE.
- **ISSUE**
  - `mem_req_valid` is high with the captured fields held stable.
  - On `mem_req_ready`, go to WAIT_RSP.
- **WAIT_RSP**
  - On `mem_rsp_valid`, register data into the owner's response, pulse the owner's `rsp_valid` for one cycle, and go to IDLE.
- **Priority**
  - Data wins over fetch unless `streak == MAX_DATA_STREAK` and both requests are valid; in that case fetch is granted.
  - `streak` increments on a data grant while `if_req_valid` is high.
  - `streak` clears on any fetch grant, and on a data grant while `if_req_valid` is low.
- Fetch is always a read: `mem_req_we = 0`, `mem_req_wstrb = 0`.
- Requesters hold `valid` and their fields stable until `ready`; the arbiter never drops an asserted request.
- `mem_rsp_valid` while in IDLE or ISSUE is ignored and sets `err`. `err` clears only on `rst`.
- `rst` (any time, including mid-transaction) forces IDLE and clears `streak`, `owner`, and `err`. Any in-flight response is lost, so memory must share the same reset.

## Timing
- Reset value of every output is 0.
- Request accepted in cycle N; `mem_req_valid` is high from N+1.
- Memory responds in cycle M ≥ N+2; the owner's `rsp_valid` and data appear in cycle M+1. In that same cycle the FSM is in IDLE and can grant again.
- Back-to-back best case: one transaction every 3 cycles (zero-wait memory that responds the cycle after accept).
- Simultaneous requests in IDLE: exactly one `ready` is asserted.
- `rsp_valid` is never high for both requesters in the same cycle.
- `streak` saturates at `MAX_DATA_STREAK` and never wraps.

## Structure
- `XLEN` and the byte-enable width come from `rtl/isa.v`. The state encoding is local parameters inside the block.
- One sub-module, `arb_priority`: combinational grant logic plus the registered `streak` counter. Its outputs are `grant_if` and `grant_d`.

## Test plan
- **Single fetch:** `if_req_valid` with addr 0x100; memory returns 0x00500093 two cycles after accept → `if_rsp_valid` pulses exactly once with 0x00500093; `d_rsp_valid` stays 0.
- **Store then load:** store 0xDEADBEEF with wstrb 0xF to 0x200, then load 0x200 → `mem_req_we = 1` on the store only; `d_rsp_rdata = 0` for the store and 0xDEADBEEF for the load.
- **Fairness:** both requesters valid continuously with `MAX_DATA_STREAK = 4` → grant order D,D,D,D,F repeating; no fetch wait exceeds 4 transactions.
- **Backpressure:** hold `mem_req_ready` low for 5 cycles → `mem_req_*` stay stable; `busy = 1`; both `*_req_ready` stay 0.
- **Spurious response:** pulse `mem_rsp_valid` in IDLE → `err = 1` and stays 1; no `rsp_valid` pulses.
- **Reset mid-transaction:** assert `rst` in WAIT_RSP → all outputs 0 immediately (asynchronously); after release, the first request is granted normally.
